// File: rtl/ysyx_24110015_mem_responder.sv
// Data-SRAM responder: one word-aligned read or byte-masked write per handshake, answered
// after LATENCY clock edges on a response channel that holds its payload until accepted.
module ysyx_24110015_mem_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wmask_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned         DEPTH    = 1 << DEPTH_LOG2;
    localparam int unsigned         CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [32:0]         SPAN     = 33'd4 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wen_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wmask_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic                  capture;
    logic                  do_access;
    logic                  rsp_done;
    logic [31:0]           off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           mem [DEPTH];

    // Unsigned wrap makes below-base addresses land far above the window.
    assign off      = addr_q - ADDR_BASE;
    assign in_range = {1'b0, off} < SPAN;
    assign idx      = DEPTH_LOG2'(off >> 2);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        do_access = 1'b0;
        rsp_done  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    capture = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    do_access = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                wen_q   <= req_wen_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                wmask_q <= req_wmask_i;
            end
            if (do_access) begin
                rdata_q <= (!wen_q && in_range) ? mem[idx] : 32'h0;
                err_q   <= !in_range;
            end else if (rsp_done) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    // NOTE: the array has no reset; clearing it would block RAM inference and isn't needed.
    always_ff @(posedge clk_i) begin
        if (do_access && wen_q && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_ysyx_24110015_mem_responder.sv
// Directed bench: instance 0 runs with LATENCY=2 (T1-T5), instance 1 with LATENCY=1 (T6).
module tb_ysyx_24110015_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wen   [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wmask [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int hs_cyc [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_24110015_mem_responder #(.LATENCY(2)) u_dut_l2 (
        .clk_i(clk), .rst_ni(rst_n[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_wen_i(req_wen[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_wmask_i(req_wmask[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
    );

    ysyx_24110015_mem_responder #(.LATENCY(1)) u_dut_l1 (
        .clk_i(clk), .rst_ni(rst_n[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_wen_i(req_wen[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_wmask_i(req_wmask[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Present a request at a negedge; the handshake happens at the following posedge.
    task automatic issue(input int d, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask);
        @(negedge clk);
        check("req_ready_before_issue", req_ready[d], 1);
        req_valid[d] = 1'b1;
        req_wen[d]   = wen;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wmask[d] = wmask;
        @(posedge clk);
        #1;
        hs_cyc[d]    = cyc;
        req_valid[d] = 1'b0;
    endtask

    // Counts posedges after the handshake until rsp_valid is seen; gives up after 20.
    task automatic await_rsp(input int d, output int lat);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid[d]) break;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic accept(input int d);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic txn(input int d, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask, input int exp_lat,
                       output logic [31:0] rdata, output logic err);
        int lat;
        issue(d, wen, addr, wdata, wmask);
        await_rsp(d, lat);
        check("latency", lat, exp_lat);
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        accept(d);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          prev_hs;
    logic [31:0] model [8];

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_wmask[d] = '0; rsp_ready[d] = 1'b0; hs_cyc[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_req_ready", req_ready[d], 1);
            check("reset_rsp_valid", rsp_valid[d], 0);
            check("reset_rsp_rdata", rsp_rdata[d], 0);
            check("reset_rsp_err", rsp_err[d], 0);
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // T1: full write then read back
        txn(0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 2, rd, er);
        check("t1_wr_rdata", rd, 32'h0);
        check("t1_wr_err", er, 0);
        check("t1_valid_dropped", rsp_valid[0], 0);
        txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 2, rd, er);
        check("t1_rd_data", rd, 32'hDEAD_BEEF);
        check("t1_rd_err", er, 0);

        // T2: single-lane write via unaligned address, then an all-zero mask
        txn(0, 1'b1, 32'h8000_0001, 32'h0000_AA00, 4'b0010, 2, rd, er);
        txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 2, rd, er);
        check("t2_lane1_merge", rd, 32'hDEAD_AAEF);
        txn(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0000, 2, rd, er);
        check("t2_zero_mask_err", er, 0);
        txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 2, rd, er);
        check("t2_zero_mask_nochange", rd, 32'hDEAD_AAEF);

        // T3: backpressure with an ignored request during RESP
        txn(0, 1'b1, 32'h8000_0020, 32'h1111_1111, 4'hF, 2, rd, er);
        issue(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        await_rsp(0, lat);
        check("t3_latency", lat, 2);
        req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = 32'h8000_0020;
        req_wdata[0] = 32'h5555_5555; req_wmask[0] = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("t3_hold_valid", rsp_valid[0], 1);
            check("t3_hold_rdata", rsp_rdata[0], 32'hDEAD_AAEF);
            check("t3_hold_req_ready", req_ready[0], 0);
        end
        req_valid[0] = 1'b0;
        accept(0);
        for (int k = 0; k < 4; k++) begin
            check("t3_no_extra_rsp", rsp_valid[0], 0);
            @(posedge clk);
            #1;
        end
        txn(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 2, rd, er);
        check("t3_ignored_write", rd, 32'h1111_1111);

        // T4: range boundaries
        txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 2, rd, er);
        check("t4_below_err", er, 1);
        check("t4_below_rdata", rd, 32'h0);
        txn(0, 1'b1, 32'h8000_4000, 32'h0BAD_0BAD, 4'hF, 2, rd, er);
        check("t4_above_err", er, 1);
        txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 2, rd, er);
        check("t4_word0_unchanged", rd, 32'hDEAD_AAEF);
        txn(0, 1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 2, rd, er);
        txn(0, 1'b0, 32'h8000_3FFC, 32'h0, 4'h0, 2, rd, er);
        check("t4_last_word_err", er, 0);
        check("t4_last_word_data", rd, 32'hCAFE_F00D);

        // T5: reset while BUSY discards the pending write
        txn(0, 1'b1, 32'h8000_0010, 32'hAAAA_0000, 4'hF, 2, rd, er);
        issue(0, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF);
        check("t5_in_busy", req_ready[0], 0);
        rst_n[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        #1;
        check("t5_req_ready", req_ready[0], 1);
        check("t5_rsp_valid", rsp_valid[0], 0);
        check("t5_rsp_rdata", rsp_rdata[0], 0);
        txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 2, rd, er);
        check("t5_write_abandoned", rd, 32'hAAAA_0000);

        // T6: LATENCY=1 back-to-back pairs, 3-cycle turnaround
        prev_hs = -1;
        for (int i = 0; i < 8; i++) begin
            model[i] = 32'h3C00_0000 ^ (32'h0101_0101 * (i + 1));
            issue(1, 1'b1, 32'h8000_0100 + 32'(4 * i), model[i], 4'hF);
            if (prev_hs >= 0) check("t6_turnaround", hs_cyc[1] - prev_hs, 3);
            prev_hs = hs_cyc[1];
            await_rsp(1, lat);
            check("t6_wr_latency", lat, 1);
            accept(1);
            issue(1, 1'b0, 32'h8000_0100 + 32'(4 * i), 32'h0, 4'h0);
            check("t6_turnaround", hs_cyc[1] - prev_hs, 3);
            prev_hs = hs_cyc[1];
            await_rsp(1, lat);
            check("t6_rd_latency", lat, 1);
            check("t6_rd_data", rsp_rdata[1], model[i]);
            accept(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
